// File: rtl/rx_sync_ctrl.sv
// Receive-side sync sequencer: steps the chain through coarse detect, frequency-offset
// estimation, fine timing and data-symbol framing, and frames the FFT input window.
module rx_sync_ctrl #(
  parameter int NFFT     = 256,
  parameter int NCP      = 64,
  parameter int FOE_TMO  = 512,
  parameter int FINE_WIN = 128,
  parameter int SYM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_i,
  input  logic             dat_stb,
  input  logic [SYM_W-1:0] num_sym,
  input  logic             coarse_det,
  input  logic             foe_vld,
  input  logic             fine_peak,
  output logic             coarse_ena,
  output logic             foe_ena,
  output logic             fine_ena,
  output logic             fft_ena,
  output logic             sym_start,
  output logic [SYM_W-1:0] sym_idx,
  output logic             sync_err,
  output logic             burst_done,
  output logic [2:0]       state
);

  // state  | meaning
  // IDLE   | waiting for cyc_i; num_sym latched on exit
  // DETECT | coarse timing block enabled, waiting for coarse_det
  // FOE    | frequency-offset estimator enabled, bounded by FOE_TMO strobes
  // FINE   | fine timing correlator enabled, bounded by FINE_WIN strobes
  // DATA   | framing NFFT+NCP sample symbols until nsym_r are done

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DETECT = 3'd1,
    S_FOE    = 3'd2,
    S_FINE   = 3'd3,
    S_DATA   = 3'd4
  } state_t;

  localparam int SYM_LEN = NFFT + NCP;
  localparam int SW      = $clog2(SYM_LEN);
  localparam int TMO_MAX = (FOE_TMO > FINE_WIN) ? FOE_TMO : FINE_WIN;
  localparam int TW      = $clog2(TMO_MAX);

  localparam logic [SW-1:0]    SAMP_LAST = SW'(SYM_LEN - 1);
  localparam logic [SW-1:0]    CP_END    = SW'(NCP);
  localparam logic [SW-1:0]    SAMP_ONE  = SW'(1);
  localparam logic [TW-1:0]    FOE_LAST  = TW'(FOE_TMO - 1);
  localparam logic [TW-1:0]    FINE_LAST = TW'(FINE_WIN - 1);
  localparam logic [TW-1:0]    TMO_ONE   = TW'(1);
  localparam logic [SYM_W-1:0] SYM_ONE   = SYM_W'(1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [SW-1:0]    samp_q, samp_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [SYM_W-1:0] nsym_q, nsym_d;
  logic             err_d, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      samp_q     <= '0;
      sym_q      <= '0;
      nsym_q     <= '0;
      sync_err   <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      samp_q     <= samp_d;
      sym_q      <= sym_d;
      nsym_q     <= nsym_d;
      sync_err   <= err_d;
      burst_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    samp_d  = samp_q;
    sym_d   = sym_q;
    nsym_d  = nsym_q;
    err_d   = 1'b0;
    done_d  = 1'b0;

    if (!cyc_i) begin
      // abort is silent; the symbol index is only kept when already idle
      state_d = S_IDLE;
      tmo_d   = '0;
      samp_d  = '0;
      if (state_q != S_IDLE) sym_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DETECT;
          nsym_d  = (num_sym == '0) ? SYM_ONE : num_sym;
          tmo_d   = '0;
          samp_d  = '0;
          sym_d   = '0;
        end
        S_DETECT: begin
          if (coarse_det) begin
            state_d = S_FOE;
            tmo_d   = '0;
          end
        end
        S_FOE: begin
          if (foe_vld) begin
            state_d = S_FINE;
            tmo_d   = '0;
          end else if (dat_stb) begin
            if (tmo_q == FOE_LAST) begin
              state_d = S_DETECT;
              tmo_d   = '0;
              err_d   = 1'b1;
            end else begin
              tmo_d = tmo_q + TMO_ONE;
            end
          end
        end
        S_FINE: begin
          if (dat_stb) begin
            // the peak sample is CP sample 0, so the window count starts at 1
            if (fine_peak) begin
              state_d = S_DATA;
              tmo_d   = '0;
              samp_d  = SAMP_ONE;
              sym_d   = '0;
            end else if (tmo_q == FINE_LAST) begin
              state_d = S_DETECT;
              tmo_d   = '0;
              err_d   = 1'b1;
            end else begin
              tmo_d = tmo_q + TMO_ONE;
            end
          end
        end
        S_DATA: begin
          if (dat_stb) begin
            if (samp_q == SAMP_LAST) begin
              samp_d = '0;
              if (sym_q == nsym_q - SYM_ONE) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                sym_d = sym_q + SYM_ONE;
              end
            end else begin
              samp_d = samp_q + SAMP_ONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tmo_d   = '0;
          samp_d  = '0;
          sym_d   = '0;
        end
      endcase
    end
  end

  assign coarse_ena = (state_q == S_DETECT);
  assign foe_ena    = (state_q == S_FOE);
  assign fine_ena   = (state_q == S_FINE);
  assign fft_ena    = (state_q == S_DATA) && dat_stb && (samp_q >= CP_END);
  assign sym_start  = (state_q == S_DATA) && dat_stb && (samp_q == CP_END);
  assign sym_idx    = sym_q;
  assign state      = state_q;

endmodule
